piso_bit_serializer: RTL and testbench



---
 rtl/piso_bit_serializer_if.sv | 24 ++
 rtl/piso_bit_serializer.sv | 154 +++++++++++++++
 tb/tb_piso_bit_serializer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/piso_bit_serializer_if.sv
// Handshake and serial-output bundle for piso_bit_serializer.
// The master modport drives words in. The slave modport is the serializer side.
interface piso_bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             last;
    logic             busy;

    modport master (
        output din, din_valid, shift_en,
        input  din_ready, sout, sout_valid, last, busy
    );

    modport slave (
        input  din, din_valid, shift_en,
        output din_ready, sout, sout_valid, last, busy
    );
endinterface

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out bit serializer with a 1-deep holding register, which lets
// back-to-back words stream out with no gap. Define SERIALIZER_PARITY_EN to append an even-parity bit to each word.
module piso_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                   clk,
    input logic                   reset,
    piso_bit_serializer_if.slave  bus
);

`ifdef SERIALIZER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_IDX = CW'(NBITS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             last_q, last_d;
`ifdef SERIALIZER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_word;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign bus.din_ready  = !reset && !hold_full_q;
    assign accept         = bus.din_valid && bus.din_ready;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = sout_valid_q;
    assign bus.last       = last_q;
    assign bus.busy       = (state_q == ST_SHIFT) || hold_full_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path infers a latch.
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        cnt_d        = cnt_q;
        sout_d       = sout_q;
        sout_valid_d = sout_valid_q;
        last_d       = last_q;
`ifdef SERIALIZER_PARITY_EN
        parity_d     = parity_q;
`endif
        load         = 1'b0;
        load_word    = bus.din;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.shift_en) begin
                    if (cnt_q == LAST_IDX) begin
                        if (hold_full_q) begin
                            load        = 1'b1;
                            load_word   = hold_q;
                            hold_full_d = 1'b0;
                        end else if (accept) begin
                            load = 1'b1;
                        end else begin
                            state_d      = ST_IDLE;
                            cnt_d        = '0;
                            sout_d       = 1'b0;
                            sout_valid_d = 1'b0;
                            last_d       = 1'b0;
                        end
                    end else begin
                        shift_d = shift_once(shift_q);
                        cnt_d   = cnt_q + 1'b1;
                        sout_d  = first_bit(shift_d);
`ifdef SERIALIZER_PARITY_EN
                        if (cnt_d == CW'(WIDTH)) sout_d = parity_q;
`endif
                        last_d  = (cnt_d == LAST_IDX);
                    end
                end
                // Accept never coincides with a hold transfer, since din_ready is low while the hold register is full.
                if (accept && !load) begin
                    hold_d      = bus.din;
                    hold_full_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            shift_d      = load_word;
            cnt_d        = '0;
            sout_d       = first_bit(load_word);
            sout_valid_d = 1'b1;
            last_d       = 1'b0;
`ifdef SERIALIZER_PARITY_EN
            parity_d     = ^load_word;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hold_full_q  <= 1'b0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_full_q  <= hold_full_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            last_q       <= last_d;
        end
    end

    // NOTE: data registers are not reset; they are only observed while a valid/full flag says so.
    always_ff @(posedge clk) begin
        shift_q  <= shift_d;
        hold_q   <= hold_d;
`ifdef SERIALIZER_PARITY_EN
        parity_q <= parity_d;
`endif
    end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Bench for piso_bit_serializer: MSB-first and LSB-first instances share stimulus, and each
// is compared every cycle against a bit-queue reference model.
module tb_piso_bit_serializer;

    localparam int WIDTH = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             din_valid;
    logic             shift_en;
    logic [WIDTH-1:0] din;

    always #5 clk = ~clk;

    piso_bit_serializer_if #(.WIDTH(WIDTH)) if_m ();
    piso_bit_serializer_if #(.WIDTH(WIDTH)) if_l ();

    assign if_m.din       = din;
    assign if_m.din_valid = din_valid;
    assign if_m.shift_en  = shift_en;
    assign if_l.din       = din;
    assign if_l.din_valid = din_valid;
    assign if_l.shift_en  = shift_en;

    piso_bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
        .clk  (clk),
        .reset(reset),
        .bus  (if_m)
    );

    piso_bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
        .clk  (clk),
        .reset(reset),
        .bus  (if_l)
    );

    int               errors = 0;
    int               checks = 0;
    bit               armed  = 1'b0;
    bit               q_m[$];
    bit               q_l[$];
    logic [WIDTH-1:0] pend[$];

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        int words = (q_m.size() + NBITS - 1) / NBITS;
        return !reset && (words < 2);
    endfunction

    task automatic check_side(input string nm, input logic so, input logic sv, input logic la,
                              input logic bu, input logic rdy, input bit front, input int n);
        bit ev = (n > 0);
        check({nm, ".sout_valid"}, sv, ev);
        check({nm, ".sout"},       so, ev ? front : 1'b0);
        check({nm, ".last"},       la, ev && (n % NBITS == 1));
        check({nm, ".busy"},       bu, ev);
        check({nm, ".din_ready"},  rdy, exp_ready());
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) q_m.push_back(w[i]);
        for (int i = 0; i < WIDTH; i++)      q_l.push_back(w[i]);
`ifdef SERIALIZER_PARITY_EN
        q_m.push_back(^w);
        q_l.push_back(^w);
`endif
    endtask

    // One clock: drive inputs, check outputs before the edge, then advance the model past the edge.
    task automatic cycle(input logic se, input logic vgate, input logic rs);
        bit acc;
        reset     = rs;
        shift_en  = se;
        din_valid = vgate && (pend.size() > 0);
        din       = din_valid ? pend[0] : WIDTH'($urandom);
        #1;
        if (armed) begin
            check_side("msb", if_m.sout, if_m.sout_valid, if_m.last, if_m.busy, if_m.din_ready,
                       (q_m.size() > 0) ? q_m[0] : 1'b0, q_m.size());
            check_side("lsb", if_l.sout, if_l.sout_valid, if_l.last, if_l.busy, if_l.din_ready,
                       (q_l.size() > 0) ? q_l[0] : 1'b0, q_l.size());
        end
        acc = din_valid && exp_ready();
        if (rs) begin
            q_m.delete();
            q_l.delete();
        end else begin
            if (se && q_m.size() > 0) begin
                void'(q_m.pop_front());
                void'(q_l.pop_front());
            end
            if (acc) push_word(pend[0]);
        end
        if (acc) void'(pend.pop_front());
        @(negedge clk);
        if (rs) armed = 1'b1;
    endtask

    task automatic run(input int n, input logic se);
        for (int i = 0; i < n; i++) cycle(se, 1'b1, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        din_valid = 1'b0;
        shift_en  = 1'b0;
        din       = '0;
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);

        // Single word, continuous enable.
        pend.push_back(8'hA5);
        run(NBITS + 3, 1'b1);
        pend.push_back(8'h01);
        run(NBITS + 3, 1'b1);

        // Back-to-back streaming through the hold register.
        pend.push_back(8'hF0);
        pend.push_back(8'h0F);
        run(2 * NBITS + 4, 1'b1);

        // Backpressure: a third word waits while shifter and hold are occupied.
        pend.push_back(8'h12);
        pend.push_back(8'h34);
        pend.push_back(8'h56);
        run(3 * NBITS + 4, 1'b1);

        // Mid-word stall.
        pend.push_back(8'h3C);
        run(3, 1'b1);
        run(3, 1'b0);
        run(NBITS + 2, 1'b1);

        // Reset after three bits, then a clean restart.
        pend.push_back(8'hFF);
        run(4, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        pend.push_back(8'h80);
        run(NBITS + 3, 1'b1);

        // Pattern fed to the downstream detector, and a parity-1 word.
        pend.push_back(8'hCC);
        pend.push_back(8'h07);
        run(2 * NBITS + 3, 1'b1);

        // Randomized traffic, stalls and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (pend.size() < 2) pend.push_back(WIDTH'($urandom));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 199) == 0);
        end
        pend.delete();
        run(3 * NBITS, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
